// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : aes_pkg                                                   |
// | Purpose  : AES state/word types, round constants and the byte-level  |
// |            transforms shared by the iterative core and key expander. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
// State layout: byte (r,c) lives at bits [127-8*(4*r+c) -: 8] (row-major).
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  word_t;

    // Index 0 and 11..15 are padding so any 4-bit index is in range.
    localparam logic [15:0][7:0] RCON = {
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
        8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00
    };

    function automatic int nr_of(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0 as the S-box needs).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box computed as inverse followed by the affine map, no table needed.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] get_b(input state_t s, input int r, input int c);
        return s[127-8*(4*r+c) -: 8];
    endfunction

    function automatic word_t col_of(input state_t s, input int c);
        return {get_b(s, 0, c), get_b(s, 1, c), get_b(s, 2, c), get_b(s, 3, c)};
    endfunction

    function automatic state_t from_cols(input word_t w0, input word_t w1,
                                         input word_t w2, input word_t w3);
        word_t  w [4];
        state_t o;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*r+c) -: 8] = w[c][31-8*r -: 8];
        return o;
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic state_t sub_bytes(input state_t s);
        state_t o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    function automatic state_t inv_sub_bytes(input state_t s);
        state_t o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
        return o;
    endfunction

    function automatic state_t shift_rows(input state_t s);
        state_t o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(4*r+c) -: 8] = get_b(s, r, (c + r) % 4);
        return o;
    endfunction

    function automatic state_t inv_shift_rows(input state_t s);
        state_t o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(4*r+c) -: 8] = get_b(s, r, (c + 4 - r) % 4);
        return o;
    endfunction

    function automatic state_t mix_columns(input state_t s);
        state_t     o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = get_b(s, 0, c); a1 = get_b(s, 1, c);
            a2 = get_b(s, 2, c); a3 = get_b(s, 3, c);
            o[127-8*(0+c) -: 8]  = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[127-8*(4+c) -: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[127-8*(8+c) -: 8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[127-8*(12+c) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic state_t inv_mix_columns(input state_t s);
        state_t     o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = get_b(s, 0, c); a1 = get_b(s, 1, c);
            a2 = get_b(s, 2, c); a3 = get_b(s, 3, c);
            o[127-8*(0+c) -: 8]  = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[127-8*(4+c) -: 8]  = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[127-8*(8+c) -: 8]  = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[127-8*(12+c) -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_expand.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : aes_key_expand                                            |
// | Purpose  : Round-key store plus a one-round-key-per-cycle expander   |
// |            for 128- and 256-bit keys, with a read port by round.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                step,
    input  logic [KEY_BITS-1:0] key,
    input  logic [3:0]          rd_idx,
    output state_t              rd_key,
    output logic                last
);

    localparam int          c_nk     = KEY_BITS / 32;
    localparam int          c_nr     = nr_of(KEY_BITS);
    localparam logic [3:0]  c_nr4    = 4'(c_nr);
    localparam logic [3:0]  c_first4 = 4'(c_nk / 4);

    state_t     r_rk [0:c_nr];
    logic [3:0] r_cnt;
    state_t     w_key_lo;
    state_t     w_key_hi;
    state_t     w_base;
    state_t     w_next;
    word_t      w_last_word;
    word_t      w_temp;
    word_t      w_c0, w_c1, w_c2, w_c3;
    logic [7:0] w_rcon;
    logic       w_rot;

    // Map the row-major key onto round keys 0 (and 1) and pick the
    // RotWord/Rcon vs plain SubWord step for the round key being built.
    if (c_nk == 8) begin : g_key256
        for (genvar r = 0; r < 4; r++) begin : g_row
            for (genvar c = 0; c < 4; c++) begin : g_col
                assign w_key_lo[127-8*(4*r+c) -: 8] = key[KEY_BITS-1-8*(r*c_nk+c) -: 8];
                assign w_key_hi[127-8*(4*r+c) -: 8] = key[KEY_BITS-1-8*(r*c_nk+c+4) -: 8];
            end
        end
        assign w_rot  = ~r_cnt[0];
        assign w_rcon = RCON[r_cnt >> 1];
    end else begin : g_key128
        assign w_key_lo = key[KEY_BITS-1 -: 128];
        assign w_key_hi = '0;
        assign w_rot    = 1'b1;
        assign w_rcon   = RCON[r_cnt];
    end

    // FIPS-197 recurrence, four words at once: base is the round key Nk words back.
    always_comb begin
        w_last_word = col_of(r_rk[r_cnt - 4'd1], 3);
        w_base      = r_rk[r_cnt - c_first4];
        w_temp      = w_rot ? (sub_word(rot_word(w_last_word)) ^ {w_rcon, 24'h000000})
                            : sub_word(w_last_word);
        w_c0        = col_of(w_base, 0) ^ w_temp;
        w_c1        = col_of(w_base, 1) ^ w_c0;
        w_c2        = col_of(w_base, 2) ^ w_c1;
        w_c3        = col_of(w_base, 3) ^ w_c2;
        w_next      = from_cols(w_c0, w_c1, w_c2, w_c3);
    end

    // Round-key store: key words on load, one generated round key per step.
    always_ff @(posedge clk) begin
        if (load) begin
            r_rk[0] <= w_key_lo;
            if (c_nk == 8) r_rk[1] <= w_key_hi;
        end else if (step) begin
            r_rk[r_cnt] <= w_next;
        end
    end

    // Index of the round key being generated; parks at Nr once done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 r_cnt <= 4'd0;
        else if (load)             r_cnt <= c_first4;
        else if (step && !last)    r_cnt <= r_cnt + 4'd1;
    end

    assign last   = (r_cnt == c_nr4);
    assign rd_key = r_rk[rd_idx];

endmodule
`default_nettype wire

// File: rtl/aes_iter_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : aes_iter_core                                             |
// | Purpose  : Iterative AES-128/256 encrypt/decrypt core, one round per |
// |            clock, with valid/ready on key, input and output.         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module aes_iter_core
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [KEY_BITS-1:0] key,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                sel_cypher,
    input  logic [127:0]        message_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        message_out,
    output logic                key_loaded
);

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_iter_core: KEY_BITS must be 128 or 256");
    end

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_kexp  = 2'd1;
    localparam logic [1:0] c_st_round = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;
    localparam logic [3:0] c_nr4      = 4'(nr_of(KEY_BITS));

    logic [1:0] r_fsm;
    logic [1:0] w_fsm_nxt;
    logic       r_key_loaded;
    logic       r_mode;
    logic       r_out_valid;
    logic [3:0] r_round;
    state_t     r_blk;
    state_t     r_out;
    logic       w_key_acc;
    logic       w_blk_acc;
    logic       w_kexp_step;
    logic       w_kexp_last;
    logic       w_final;
    logic [3:0] w_rd_idx;
    state_t     w_rd_key;
    state_t     w_enc;
    state_t     w_dec;
    state_t     w_round_out;

    aes_key_expand #(
        .KEY_BITS (KEY_BITS)
    ) u_key_expand (
        .clk    (clk),
        .reset  (reset),
        .load   (w_key_acc),
        .step   (w_kexp_step),
        .key    (key),
        .rd_idx (w_rd_idx),
        .rd_key (w_rd_key),
        .last   (w_kexp_last)
    );

    assign w_kexp_step = (r_fsm == c_st_kexp);
    assign w_final     = (r_round == c_nr4);

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_fsm <= c_st_idle;
        else       r_fsm <= w_fsm_nxt;
    end

    // Next state and handshake readies; a key offer masks in_ready in IDLE.
    always_comb begin
        w_fsm_nxt = r_fsm;
        key_ready = 1'b0;
        in_ready  = 1'b0;
        w_key_acc = 1'b0;
        w_blk_acc = 1'b0;
        case (r_fsm)
            c_st_idle: begin
                key_ready = 1'b1;
                in_ready  = r_key_loaded & ~key_valid;
                w_key_acc = key_valid;
                w_blk_acc = in_valid & r_key_loaded & ~key_valid;
                if (w_key_acc)      w_fsm_nxt = c_st_kexp;
                else if (w_blk_acc) w_fsm_nxt = c_st_round;
            end
            c_st_kexp:  if (w_kexp_last) w_fsm_nxt = c_st_idle;
            c_st_round: if (w_final)     w_fsm_nxt = c_st_done;
            c_st_done:  if (out_ready)   w_fsm_nxt = c_st_idle;
            default:    w_fsm_nxt = c_st_idle;
        endcase
    end

    // Round-key select: whitening key at accept, then per-round key by mode.
    always_comb begin
        if (r_fsm == c_st_round) w_rd_idx = r_mode ? r_round : (c_nr4 - r_round);
        else                     w_rd_idx = sel_cypher ? 4'd0 : c_nr4;
    end

    // One full encrypt or decrypt round; the last round drops (Inv)MixColumns.
    always_comb begin
        w_enc = shift_rows(sub_bytes(r_blk));
        if (!w_final) w_enc = mix_columns(w_enc);
        w_enc = w_enc ^ w_rd_key;
        w_dec = inv_sub_bytes(inv_shift_rows(r_blk)) ^ w_rd_key;
        if (!w_final) w_dec = inv_mix_columns(w_dec);
        w_round_out = r_mode ? w_enc : w_dec;
    end

    // Datapath: block state, round counter, result register and key status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blk        <= '0;
            r_round      <= 4'd0;
            r_mode       <= 1'b0;
            r_out        <= '0;
            r_out_valid  <= 1'b0;
            r_key_loaded <= 1'b0;
        end else begin
            case (r_fsm)
                c_st_idle: begin
                    if (w_key_acc) begin
                        r_key_loaded <= 1'b0;
                    end else if (w_blk_acc) begin
                        r_mode  <= sel_cypher;
                        r_blk   <= message_in ^ w_rd_key;
                        r_round <= 4'd1;
                    end
                end
                c_st_kexp: begin
                    if (w_kexp_last) r_key_loaded <= 1'b1;
                end
                c_st_round: begin
                    r_blk <= w_round_out;
                    if (w_final) begin
                        r_out       <= w_round_out;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_round <= r_round + 4'd1;
                    end
                end
                c_st_done: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign out_valid   = r_out_valid;
    assign message_out = r_out;
    assign key_loaded  = r_key_loaded;

endmodule
`default_nettype wire

// File: tb/tb_aes_iter_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_aes_iter_core                                          |
// | Purpose  : Directed self-checking bench for aes_iter_core, one       |
// |            AES-128 and one AES-256 instance on a shared clock/reset. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_aes_iter_core;

    localparam logic [127:0] c_key128 = 128'h2B28AB097EAEF7CF15D2154F16A6883C;
    localparam logic [127:0] c_pt128  = 128'h328831E0435A3137F6309807A88DA234;
    localparam logic [127:0] c_ct128  = 128'h3902DC1925DC116A8409850B1DFB9732;
    localparam logic [127:0] c_ct_zero = 128'h66EF88CAE98A4C344B2CFA2BD43B592E;
    localparam logic [255:0] c_key256 =
        256'h0004080C1014181C0105090D1115191D02060A0E12161A1E03070B0F13171B1F;
    localparam logic [127:0] c_pt256  = 128'h004488CC115599DD2266AAEE3377BBFF;
    localparam logic [127:0] c_ct256  = 128'h8E51EA4BA267FC49B7454960CABF9089;

    logic         clk = 1'b0;
    logic         reset;
    logic         kv   [2];
    logic         kr   [2];
    logic         iv   [2];
    logic         ir   [2];
    logic         sel  [2];
    logic         ov   [2];
    logic         ordy [2];
    logic         kl   [2];
    logic [255:0] key_s [2];
    logic [127:0] mi   [2];
    logic [127:0] mo   [2];
    int           n_cmp = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    aes_iter_core #(.KEY_BITS(128)) u_dut128 (
        .clk(clk), .reset(reset),
        .key_valid(kv[0]), .key_ready(kr[0]), .key(key_s[0][127:0]),
        .in_valid(iv[0]), .in_ready(ir[0]), .sel_cypher(sel[0]), .message_in(mi[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .message_out(mo[0]), .key_loaded(kl[0])
    );

    aes_iter_core #(.KEY_BITS(256)) u_dut256 (
        .clk(clk), .reset(reset),
        .key_valid(kv[1]), .key_ready(kr[1]), .key(key_s[1]),
        .in_valid(iv[1]), .in_ready(ir[1]), .sel_cypher(sel[1]), .message_in(mi[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .message_out(mo[1]), .key_loaded(kl[1])
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until key_loaded rises (bounded) and check the count.
    task automatic wait_kexp(input int d, input int exp_cyc, input string tag);
        int n;
        n = 0;
        while (!kl[d] && n < 60) begin
            tick();
            n++;
        end
        check($sformatf("%s_kexp_cycles", tag), n, exp_cyc);
    endtask

    task automatic load_key(input int d, input logic [255:0] k, input int exp_cyc, input string tag);
        key_s[d] = k;
        kv[d]    = 1'b1;
        tick();
        kv[d]    = 1'b0;
        check($sformatf("%s_loaded_low", tag), kl[d], 1'b0);
        wait_kexp(d, exp_cyc, tag);
    endtask

    // Count edges from the accepting edge until out_valid (bounded), check result.
    task automatic wait_out(input int d, input logic [127:0] exp, input int nr, input string tag);
        int n;
        n = 0;
        while (!ov[d] && n < 60) begin
            tick();
            n++;
        end
        check($sformatf("%s_latency", tag), n, nr);
        check($sformatf("%s_data", tag), mo[d], exp);
    endtask

    task automatic run_blk(input int d, input logic [127:0] blk, input logic enc,
                           input logic [127:0] exp, input int nr, input string tag);
        mi[d]  = blk;
        sel[d] = enc;
        iv[d]  = 1'b1;
        #1;
        check($sformatf("%s_in_ready", tag), ir[d], 1'b1);
        tick();
        iv[d]  = 1'b0;
        wait_out(d, exp, nr, tag);
        if (ordy[d]) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            kv[d] = 1'b0; iv[d] = 1'b0; sel[d] = 1'b0; ordy[d] = 1'b1;
            key_s[d] = '0; mi[d] = '0;
        end

        // Reset state
        tick();
        check("rst_key_ready", kr[0], 1'b1);
        check("rst_in_ready", ir[0], 1'b0);
        check("rst_out_valid", ov[0], 1'b0);
        check("rst_key_loaded", kl[0], 1'b0);
        check("rst_msg_out", mo[0], 128'h0);
        check("rst_msg_out_256", mo[1], 128'h0);
        tick();
        reset = 1'b0;
        tick();

        // No key yet: a block offer must not be taken
        mi[0] = '0; sel[0] = 1'b1; iv[0] = 1'b1;
        repeat (3) begin
            tick();
            check("nokey_in_ready", ir[0], 1'b0);
        end
        check("nokey_out_valid", ov[0], 1'b0);
        iv[0] = 1'b0;

        // All-zero key and block
        load_key(0, 256'h0, 10, "kzero");
        run_blk(0, 128'h0, 1'b1, c_ct_zero, 10, "enc_zero");

        // Key and block offered together: key wins, block waits for the new key
        key_s[0] = {128'h0, c_key128};
        kv[0] = 1'b1;
        mi[0] = c_pt128; sel[0] = 1'b1; iv[0] = 1'b1;
        #1;
        check("prio_in_ready", ir[0], 1'b0);
        check("prio_key_ready", kr[0], 1'b1);
        tick();
        kv[0] = 1'b0;
        check("prio_key_loaded_drop", kl[0], 1'b0);
        check("prio_kexp_in_ready", ir[0], 1'b0);
        check("prio_kexp_key_ready", kr[0], 1'b0);
        wait_kexp(0, 10, "prio");
        tick();
        iv[0] = 1'b0;
        wait_out(0, c_ct128, 10, "prio_enc");
        tick();

        // Decrypt under the same key
        run_blk(0, c_ct128, 1'b0, c_pt128, 10, "dec128");

        // Output backpressure
        ordy[0] = 1'b0;
        run_blk(0, c_pt128, 1'b1, c_ct128, 10, "bp_enc");
        repeat (20) begin
            tick();
            check("bp_hold", {ov[0], ir[0], kr[0], mo[0]}, {1'b1, 1'b0, 1'b0, c_ct128});
        end
        ordy[0] = 1'b1;
        tick();
        check("bp_release_out_valid", ov[0], 1'b0);
        check("bp_release_in_ready", ir[0], 1'b1);

        // Reset while round 5 is in progress
        mi[0] = c_pt128; sel[0] = 1'b1; iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        repeat (4) tick();
        check("round_in_ready", ir[0], 1'b0);
        reset = 1'b1;
        #1;
        check("midrst_out_valid", ov[0], 1'b0);
        check("midrst_key_loaded", kl[0], 1'b0);
        check("midrst_key_ready", kr[0], 1'b1);
        tick();
        reset = 1'b0;
        tick();
        load_key(0, {128'h0, c_key128}, 10, "kreload");
        run_blk(0, c_pt128, 1'b1, c_ct128, 10, "enc_after_rst");

        // AES-256 instance
        load_key(1, c_key256, 13, "k256");
        run_blk(1, c_pt256, 1'b1, c_ct256, 14, "enc256");
        run_blk(1, c_ct256, 1'b0, c_pt256, 14, "dec256");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_iter_core.md
Name: aes_iter_core

Overview:
- Iterative AES block-cipher core, one round per clock.
- Parametrised successor to the fixed AES128 top: supports 128- or 256-bit keys and run-time selection of encrypt or decrypt (sel_cypher).
- Uses valid/ready handshakes on key, input and output. A loaded key is expanded once into a round-key store and reused for any number of blocks.
- Sits between the message source and the output consumer in the crypto datapath.

Parameters:
- KEY_BITS, 128, key length. Only 128 or 256 are legal; any other value is an elaboration-time $error. Nk = KEY_BITS/32, Nr = Nk+6 (10 or 14).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- key_valid  input  1  key offered
- key_ready  output  1  core can accept a key
- key  input  KEY_BITS  cipher key. Byte (r,c), r=0..3, c=0..Nk-1, sits at bits [KEY_BITS-1-8*(r*Nk+c) -: 8] (row-major).
- in_valid  input  1  block offered
- in_ready  output  1  core can accept a block
- sel_cypher  input  1  sampled with the block: 1 = encrypt, 0 = decrypt
- message_in  input  128  input state. Byte (r,c) at [127-8*(r*4+c) -: 8] (row-major).
- out_valid  output  1  message_out valid
- out_ready  input  1  consumer accepts
- message_out  output  128  result, same byte layout as message_in
- key_loaded  output  1  a full round-key set is stored

Behaviour:
- Reset: asynchronous, active-high. Effects:
  - state FSM -> IDLE; key_loaded=0; out_valid=0; message_out=0.
  - key_ready=1; in_ready=0.
  - Round-key store is not reset.
  - Reset asserted mid-expansion or mid-round aborts the operation. No output is produced and the key must be reloaded.
- FSM states: IDLE, KEXP, ROUND, DONE.
- IDLE:
  - key_ready=1.
  - in_ready = key_loaded.
  - If key_valid and in_valid are both high in the same cycle, the key wins and the block is not accepted (in_ready forced 0 that cycle).
- Key accept (IDLE & key_valid):
  - rk[0] (and rk[1] if Nk=8) is written directly from key.
  - key_loaded <= 0.
  - -> KEXP.
- KEXP:
  - Generates one 128-bit round key (4 words) per cycle using the FIPS-197 recurrence, with Rcon and (for Nk=8) the extra SubWord.
  - Takes Nr cycles for 128-bit keys, Nr-1 cycles for 256-bit keys.
  - Then key_loaded <= 1, -> IDLE.
  - key_ready=0 and in_ready=0 throughout.
- Block accept (IDLE & in_valid & in_ready):
  - Latch the mode.
  - Encrypt: state <= message_in ^ rk[0]. Decrypt: state <= message_in ^ rk[Nr].
  - round <= 1, -> ROUND.
- ROUND, one round per cycle:
  - Encrypt: SubBytes, ShiftRows, MixColumns, then AddRoundKey rk[round]. MixColumns is skipped when round==Nr.
  - Decrypt: InvShiftRows, InvSubBytes, AddRoundKey rk[Nr-round], then InvMixColumns. InvMixColumns is skipped when round==Nr.
  - After round Nr: message_out <= state, out_valid <= 1, -> DONE.
- Latency: a block accepted at edge k has out_valid high after edge k+Nr (10 or 14 cycles).
- DONE:
  - message_out and out_valid are held stable until out_ready.
  - On out_ready: out_valid <= 0, -> IDLE.
  - Peak throughput: one block per Nr+2 cycles.
- Backpressure: in_ready and key_ready stay 0 in ROUND and DONE. A key change is never possible with a block in flight.
- Round counter width is 4 bits; it never exceeds Nr.
- No combinational path from any input to key_ready, in_ready or out_valid, except the key-vs-block priority in IDLE, which gates only in_ready.

Decomposition:
- aes_pkg holds:
  - typedef state_t (logic [127:0]) and typedef word_t (logic [31:0]);
  - localparam RCON array;
  - functions sbox, inv_sbox, xtime, sub_bytes, inv_sub_bytes, shift_rows, inv_shift_rows, mix_columns, inv_mix_columns;
  - function nr_of(key_bits).
- One sub-module: aes_key_expand. It holds the KEXP counter/recurrence and the round-key store. Its ports are parametrised by KEY_BITS, and it provides a read port indexed by round.

Test Plan:
- AES-128 encrypt: key 128'h2B28AB097EAEF7CF15D2154F16A6883C, block 128'h328831E0435A3137F6309807A88DA234, sel_cypher=1 -> message_out 128'h3902DC1925DC116A8409850B1DFB9732; out_valid exactly 10 cycles after in handshake.
- AES-128 decrypt, same key: block 128'h3902DC1925DC116A8409850B1DFB9732, sel_cypher=0 -> 128'h328831E0435A3137F6309807A88DA234.
- AES-256 (KEY_BITS=256): key row-major over bytes 00..1F (row0 = 0004080C1014181C, ...), block 128'h004488CC115599DD2266AAEE3377BBFF, encrypt -> 128'h8E51EA4BA267FC49B7454960CABF9089 after 14 cycles. Decrypt of that result returns the plaintext.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> message_out stable, in_ready=0, key_ready=0. Release -> out_valid drops the next cycle and in_ready rises.
- Handshake priority and key gating: before any key, in_valid=1 -> in_ready=0, no acceptance. key_valid and in_valid together in IDLE -> only the key is taken and key_loaded drops during KEXP. The pending block is accepted once key_loaded=1 and encrypts under the new key.
- Reset mid-ROUND (round 5) -> out_valid=0, key_loaded=0, key_ready=1 immediately, with no clock edge needed. Reload the key and the vector from the first scenario passes again.
